// File: rtl/auth_pkg.sv
// -----------------------------------------------------------------------------
// auth_pkg : shared types and helpers for the OTP verifier
// Rev 1.0  : initial release
// -----------------------------------------------------------------------------
`default_nettype none

package auth_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    GRANT   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Width of the shared interval timer: wide enough for the longest interval.
  function automatic int timer_width(input int timeout_cycles,
                                     input int lock_cycles,
                                     input int grant_cycles);
    int m;
    m = timeout_cycles;
    if (lock_cycles > m) m = lock_cycles;
    if (grant_cycles > m) m = grant_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/auth_timer.sv
// -----------------------------------------------------------------------------
// auth_timer : loadable down-counter; done is high during the last counted cycle
// Rev 1.0    : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module auth_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // The edge that sees count == 1 is the one that ends the interval.
  assign done = (count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/otp_verifier.sv
// -----------------------------------------------------------------------------
// otp_verifier : captures a one-time code and checks keyed digit entries
// Rev 1.0      : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module otp_verifier
  import auth_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int MAX_TRIES    = 3,
  parameter int GRANT_CYCLES = 8,
  parameter int LOCK_CYCLES  = 16,
  parameter int OTP_TIMEOUT  = 100
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          otp_load,
  input  logic [DIGIT_W*DIGITS-1:0]     otp_in,
  input  logic                          digit_valid,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          clear,
  output logic                          armed,
  output logic                          grant,
  output logic                          deny,
  output logic                          expired,
  output logic                          locked,
  output logic [$clog2(DIGITS+1)-1:0]   digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int OTP_W   = DIGIT_W * DIGITS;
  localparam int CNT_W   = $clog2(DIGITS + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int TIMER_W = timer_width(OTP_TIMEOUT, LOCK_CYCLES, GRANT_CYCLES);

  state_t             state, state_next;
  logic [OTP_W-1:0]   otp, otp_next;
  logic [OTP_W-1:0]   entry, entry_next, entry_shift;
  logic [CNT_W-1:0]   count_next;
  logic [TRY_W-1:0]   tries_next;
  logic               deny_next, expired_next;
  logic               timer_load, timer_done;
  logic [TIMER_W-1:0] timer_value;

  auth_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  assign entry_shift = (entry << DIGIT_W) | OTP_W'(digit_in);

  always_comb begin
    state_next   = state;
    otp_next     = otp;
    entry_next   = entry;
    count_next   = digit_count;
    tries_next   = tries_left;
    deny_next    = 1'b0;
    expired_next = 1'b0;
    timer_load   = 1'b0;
    timer_value  = TIMER_W'(OTP_TIMEOUT);

    case (state)
      IDLE: begin
        if (otp_load) begin
          otp_next   = otp_in;
          entry_next = '0;
          count_next = '0;
          timer_load = 1'b1;
          state_next = ARMED;
        end
      end

      ARMED: begin
        if (timer_done) begin
          expired_next = 1'b1;
          otp_next     = '0;
          entry_next   = '0;
          count_next   = '0;
          state_next   = IDLE;
        end else if (otp_load) begin
          otp_next   = otp_in;
          entry_next = '0;
          count_next = '0;
          timer_load = 1'b1;
        end else if (clear) begin
          entry_next = '0;
          count_next = '0;
        end else if (digit_valid) begin
          if (digit_count == CNT_W'(DIGITS - 1)) begin
            entry_next = '0;
            count_next = '0;
            if (entry_shift == otp) begin
              otp_next    = '0;
              tries_next  = TRY_W'(MAX_TRIES);
              timer_load  = 1'b1;
              timer_value = TIMER_W'(GRANT_CYCLES);
              state_next  = GRANT;
            end else begin
              deny_next = 1'b1;
              if (tries_left != '0) tries_next = tries_left - 1'b1;
              // Last try used up: the code is burned and the keypad locks.
              if (tries_left <= TRY_W'(1)) begin
                otp_next    = '0;
                timer_load  = 1'b1;
                timer_value = TIMER_W'(LOCK_CYCLES);
                state_next  = LOCKOUT;
              end
            end
          end else begin
            entry_next = entry_shift;
            count_next = digit_count + 1'b1;
          end
        end
      end

      GRANT: begin
        if (timer_done) state_next = IDLE;
      end

      LOCKOUT: begin
        if (timer_done) begin
          tries_next = TRY_W'(MAX_TRIES);
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      otp         <= '0;
      entry       <= '0;
      digit_count <= '0;
      tries_left  <= TRY_W'(MAX_TRIES);
      deny        <= 1'b0;
      expired     <= 1'b0;
    end else begin
      state       <= state_next;
      otp         <= otp_next;
      entry       <= entry_next;
      digit_count <= count_next;
      tries_left  <= tries_next;
      deny        <= deny_next;
      expired     <= expired_next;
    end
  end

  assign armed  = (state == ARMED);
  assign grant  = (state == GRANT);
  assign locked = (state == LOCKOUT);

endmodule

`default_nettype wire

// File: tb/tb_otp_verifier.sv
// -----------------------------------------------------------------------------
// tb_otp_verifier : directed self-checking bench for otp_verifier
// Rev 1.0         : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_otp_verifier;

  logic        clk = 1'b0;
  logic        reset, otp_load, digit_valid, clear;
  logic [15:0] otp_in;
  logic [3:0]  digit_in;
  logic        armed, grant, deny, expired, locked;
  logic [2:0]  digit_count;
  logic [1:0]  tries_left;

  int checks = 0;
  int errors = 0;

  otp_verifier #(
    .DIGITS(4), .MAX_TRIES(3), .GRANT_CYCLES(8), .LOCK_CYCLES(16), .OTP_TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset), .otp_load(otp_load), .otp_in(otp_in),
    .digit_valid(digit_valid), .digit_in(digit_in), .clear(clear),
    .armed(armed), .grant(grant), .deny(deny), .expired(expired), .locked(locked),
    .digit_count(digit_count), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  // After tick, outputs reflect the edge just taken and inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_otp(input logic [15:0] v);
    otp_in = v; otp_load = 1'b1;
    tick();
    otp_load = 1'b0;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] v);
    enter_digit(v[15:12]); enter_digit(v[11:8]); enter_digit(v[7:4]); enter_digit(v[3:0]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({armed, grant, deny, expired, locked} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {armed, grant, deny, expired, locked});
    end
    checks++;
    if (digit_count !== 3'd0 || tries_left !== 2'd3) begin
      errors++; $display("FAIL reset_counts got cnt=%0d tries=%0d want cnt=0 tries=3", digit_count, tries_left);
    end
  endtask

  task automatic test_correct_entry();
    load_otp(16'hA3C5);
    checks++;
    if (armed !== 1'b1 || digit_count !== 3'd0) begin
      errors++; $display("FAIL correct_armed got armed=%b cnt=%0d want armed=1 cnt=0", armed, digit_count);
    end
    enter_digit(4'hA); enter_digit(4'h3); enter_digit(4'hC);
    checks++;
    if (digit_count !== 3'd3 || grant !== 1'b0) begin
      errors++; $display("FAIL correct_cnt3 got cnt=%0d grant=%b want cnt=3 grant=0", digit_count, grant);
    end
    enter_digit(4'h5);
    checks++;
    if (grant !== 1'b1 || armed !== 1'b0 || tries_left !== 2'd3 || digit_count !== 3'd0) begin
      errors++; $display("FAIL correct_grant1 got grant=%b armed=%b tries=%0d cnt=%0d want 1 0 3 0",
                         grant, armed, tries_left, digit_count);
    end
    for (int i = 2; i <= 8; i++) begin
      tick();
      checks++;
      if (grant !== 1'b1) begin
        errors++; $display("FAIL correct_grant_hold cycle %0d got %b want 1", i, grant);
      end
    end
    tick();
    checks++;
    if (grant !== 1'b0 || armed !== 1'b0) begin
      errors++; $display("FAIL correct_grant_end got grant=%b armed=%b want 0 0", grant, armed);
    end
    enter_code(16'hA3C5);
    tick();
    checks++;
    if (grant !== 1'b0 || deny !== 1'b0 || digit_count !== 3'd0) begin
      errors++; $display("FAIL correct_reuse got grant=%b deny=%b cnt=%0d want 0 0 0", grant, deny, digit_count);
    end
  endtask

  task automatic test_wrong_entry();
    load_otp(16'h1234);
    enter_code(16'h1239);
    checks++;
    if (deny !== 1'b1 || tries_left !== 2'd2 || armed !== 1'b1 || digit_count !== 3'd0) begin
      errors++; $display("FAIL wrong_deny got deny=%b tries=%0d armed=%b cnt=%0d want 1 2 1 0",
                         deny, tries_left, armed, digit_count);
    end
    tick();
    checks++;
    if (deny !== 1'b0) begin
      errors++; $display("FAIL wrong_deny_pulse got %b want 0", deny);
    end
    enter_code(16'h1234);
    checks++;
    if (grant !== 1'b1 || tries_left !== 2'd3 || deny !== 1'b0) begin
      errors++; $display("FAIL wrong_retry_grant got grant=%b tries=%0d deny=%b want 1 3 0", grant, tries_left, deny);
    end
    repeat (8) tick();
  endtask

  task automatic test_lockout();
    load_otp(16'h5555);
    for (int t = 1; t <= 3; t++) begin
      enter_code(16'h0000);
      checks++;
      if (deny !== 1'b1 || tries_left !== 2'(3 - t)) begin
        errors++; $display("FAIL lock_deny try %0d got deny=%b tries=%0d want 1 %0d", t, deny, tries_left, 3 - t);
      end
    end
    checks++;
    if (locked !== 1'b1 || armed !== 1'b0) begin
      errors++; $display("FAIL lock_enter got locked=%b armed=%b want 1 0", locked, armed);
    end
    for (int i = 2; i <= 16; i++) begin
      otp_in      = 16'h0000;
      otp_load    = (i == 4);
      digit_in    = 4'h0;
      digit_valid = (i == 6) || (i == 7);
      tick();
      checks++;
      if (locked !== 1'b1 || armed !== 1'b0) begin
        errors++; $display("FAIL lock_hold cycle %0d got locked=%b armed=%b want 1 0", i, locked, armed);
      end
    end
    otp_load = 1'b0; digit_valid = 1'b0;
    tick();
    checks++;
    if (locked !== 1'b0 || armed !== 1'b0 || tries_left !== 2'd3) begin
      errors++; $display("FAIL lock_exit got locked=%b armed=%b tries=%0d want 0 0 3", locked, armed, tries_left);
    end
  endtask

  task automatic test_expiry();
    load_otp(16'hA3C5);
    enter_digit(4'hA); enter_digit(4'h3);
    checks++;
    if (digit_count !== 3'd2) begin
      errors++; $display("FAIL exp_cnt2 got %0d want 2", digit_count);
    end
    enter_digit(4'hC);
    repeat (96) tick();
    checks++;
    if (expired !== 1'b0 || armed !== 1'b1) begin
      errors++; $display("FAIL exp_early at 99 got expired=%b armed=%b want 0 1", expired, armed);
    end
    digit_in = 4'h5; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    checks++;
    if (expired !== 1'b1 || armed !== 1'b0 || digit_count !== 3'd0 || grant !== 1'b0 || deny !== 1'b0) begin
      errors++; $display("FAIL exp_pulse got exp=%b armed=%b cnt=%0d grant=%b deny=%b want 1 0 0 0 0",
                         expired, armed, digit_count, grant, deny);
    end
    tick();
    checks++;
    if (expired !== 1'b0 || grant !== 1'b0 || deny !== 1'b0 || tries_left !== 2'd3) begin
      errors++; $display("FAIL exp_after got exp=%b grant=%b deny=%b tries=%0d want 0 0 0 3",
                         expired, grant, deny, tries_left);
    end
  endtask

  task automatic test_clear_reload();
    load_otp(16'h1111);
    enter_code(16'h2222);
    enter_digit(4'h1); enter_digit(4'h1); enter_digit(4'h1);
    checks++;
    if (digit_count !== 3'd3 || tries_left !== 2'd2) begin
      errors++; $display("FAIL clr_pre got cnt=%0d tries=%0d want 3 2", digit_count, tries_left);
    end
    digit_in = 4'h1; digit_valid = 1'b1; clear = 1'b1;
    tick();
    digit_valid = 1'b0; clear = 1'b0;
    checks++;
    if (digit_count !== 3'd0 || tries_left !== 2'd2 || grant !== 1'b0 || armed !== 1'b1) begin
      errors++; $display("FAIL clr_apply got cnt=%0d tries=%0d grant=%b armed=%b want 0 2 0 1",
                         digit_count, tries_left, grant, armed);
    end
    load_otp(16'h2222);
    checks++;
    if (tries_left !== 2'd2 || armed !== 1'b1) begin
      errors++; $display("FAIL reload_tries got tries=%0d armed=%b want 2 1", tries_left, armed);
    end
    repeat (99) tick();
    checks++;
    if (expired !== 1'b0 || armed !== 1'b1) begin
      errors++; $display("FAIL reload_timer at 99 got expired=%b armed=%b want 0 1", expired, armed);
    end
    tick();
    checks++;
    if (expired !== 1'b1 || tries_left !== 2'd2) begin
      errors++; $display("FAIL reload_expiry got expired=%b tries=%0d want 1 2", expired, tries_left);
    end
  endtask

  task automatic test_reset_mid_grant();
    load_otp(16'h0F0F);
    enter_code(16'h0F0F);
    repeat (3) tick();
    checks++;
    if (grant !== 1'b1) begin
      errors++; $display("FAIL rstg_cycle4 got %b want 1", grant);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({armed, grant, deny, expired, locked} !== 5'b0 || tries_left !== 2'd3 || digit_count !== 3'd0) begin
      errors++; $display("FAIL rstg_outputs got flags=%b tries=%0d cnt=%0d want 00000 3 0",
                         {armed, grant, deny, expired, locked}, tries_left, digit_count);
    end
  endtask

  initial begin
    reset = 1'b1; otp_load = 1'b0; otp_in = '0;
    digit_valid = 1'b0; digit_in = '0; clear = 1'b0;
    test_reset();
    test_correct_entry();
    test_wrong_entry();
    test_lockout();
    test_expiry();
    test_clear_reload();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
